motor_cmd_dispatcher: RTL

MOTOR_CMD_DISPATCHER -- requirements
Module: motor_cmd_dispatcher

---
 rtl/motor_cmd_dispatcher_pkg.sv | 14 +
 rtl/motor_cmd_slot.sv | 66 ++++++
 rtl/motor_cmd_dispatcher.sv | 126 ++++++++++++
 3 files changed

// File: rtl/motor_cmd_dispatcher_pkg.sv
// Shared widths, word field positions and state encodings for the motor
// command dispatcher and its per-channel slots.
package motor_cmd_dispatcher_pkg;
  localparam int NUM_CH_DEF = 10;
  localparam int DIV_W      = 15;
  localparam int STEP_W     = 13;
  localparam int CH_W       = 4;
  localparam int DIV_LSB    = 4;
  localparam int STEP_LSB   = 19;

  typedef enum logic {P_IDLE, P_DATA} parser_state_e;

  typedef enum logic [1:0] {S_FREE, S_HELD, S_LOADED} slot_state_e;
endpackage

// File: rtl/motor_cmd_slot.sv
// One channel's command slot: holds divider/steps from commit until the next
// commit, issues the load pulse and waits for the motor's busy-edge acknowledge.
module motor_cmd_slot
  import motor_cmd_dispatcher_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              commit_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [STEP_W-1:0] steps_i,
  input  logic              active_i,
  output logic              load_o,
  output logic              pending_o,
  output logic [DIV_W-1:0]  div_o,
  output logic [STEP_W-1:0] steps_o
);
  slot_state_e       state_q, state_d;
  logic              active_q;
  logic              load_q, load_d;
  logic [DIV_W-1:0]  div_q;
  logic [STEP_W-1:0] steps_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_FREE;
      active_q <= 1'b0;
      load_q   <= 1'b0;
      div_q    <= '0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_i;
      load_q   <= load_d;
      if (commit_i) begin
        div_q   <= div_i;
        steps_q <= steps_i;
      end
    end
  end

  // A zero-step command is recorded but never armed, so the slot stays free.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    case (state_q)
      S_FREE: begin
        if (commit_i && (steps_i != '0)) state_d = S_HELD;
      end
      S_HELD: begin
        if (!active_i) begin
          load_d  = 1'b1;
          state_d = S_LOADED;
        end
      end
      S_LOADED: begin
        if (!active_q && active_i) state_d = S_FREE;
      end
      default: state_d = S_FREE;
    endcase
  end

  assign load_o    = load_q;
  assign pending_o = (state_q != S_FREE);
  assign div_o     = div_q;
  assign steps_o   = steps_q;
endmodule

// File: rtl/motor_cmd_dispatcher.sv
// UART frame parser (channel byte + 32-bit LSB-first word) feeding NUM_CH
// independent motor command slots, with overrun and frame-error reporting.
module motor_cmd_dispatcher
  import motor_cmd_dispatcher_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic                     CLK_SE_AR,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic [NUM_CH-1:0]        mr_active,
  output logic [NUM_CH-1:0]        mr_load,
  output logic [DIV_W*NUM_CH-1:0]  mr_divider,
  output logic [STEP_W*NUM_CH-1:0] mr_steps,
  output logic [NUM_CH-1:0]        pending,
  output logic                     frame_err,
  output logic                     overrun
);
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  parser_state_e     pstate_q, pstate_d;
  logic [1:0]        idx_q, idx_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [23:0]       word_q, word_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              commit_ok;
  logic              pend_sel;
  logic [DIV_W-1:0]  div_w;
  logic [STEP_W-1:0] steps_w;

  always_ff @(posedge CLK_SE_AR) begin
    if (rst) begin
      pstate_q <= P_IDLE;
      idx_q    <= '0;
      tmo_q    <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
    ch_q   <= ch_d;
    word_q <= word_d;
  end

  // The last byte is not shifted in; fields are cut straight from it plus the held bytes.
  assign div_w   = DIV_W'({rx_data, word_q} >> DIV_LSB);
  assign steps_w = STEP_W'({rx_data, word_q} >> STEP_LSB);

  always_comb begin
    pend_sel = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) pend_sel = pending[c];
    end
  end

  always_comb begin
    pstate_d  = pstate_q;
    idx_d     = idx_q;
    ch_d      = ch_q;
    word_d    = word_q;
    tmo_d     = tmo_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    commit_ok = 1'b0;
    case (pstate_q)
      P_IDLE: begin
        tmo_d = '0;
        if (rx_valid) begin
          ch_d     = rx_data[CH_W-1:0];
          idx_d    = '0;
          pstate_d = P_DATA;
        end
      end
      P_DATA: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (idx_q == 2'd3) begin
            pstate_d = P_IDLE;
            idx_d    = '0;
            if (int'(ch_q) >= NUM_CH) ferr_d = 1'b1;
            else if (pend_sel)        ovr_d  = 1'b1;
            else                      commit_ok = 1'b1;
          end else begin
            word_d = {rx_data, word_q[23:8]};
            idx_d  = idx_q + 2'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          pstate_d = P_IDLE;
          idx_d    = '0;
          tmo_d    = '0;
          ferr_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: pstate_d = P_IDLE;
    endcase
  end

  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    motor_cmd_slot u_slot (
      .clk_i     (CLK_SE_AR),
      .rst_i     (rst),
      .commit_i  (commit_ok && (ch_q == CH_W'(c))),
      .div_i     (div_w),
      .steps_i   (steps_w),
      .active_i  (mr_active[c]),
      .load_o    (mr_load[c]),
      .pending_o (pending[c]),
      .div_o     (mr_divider[c*DIV_W +: DIV_W]),
      .steps_o   (mr_steps[c*STEP_W +: STEP_W])
    );
  end
endmodule
